rr_decoder_arbiter: RTL

// - Round-robin arbiter sharing one N-way decoded select bus among N requesters.
// - Picks one requester, holds the grant until release, and drives a binary index plus enable.
// - The index and enable drive an internal En-gated binary-to-one-hot decoder, which produces Gnt.
// - Sits between requesting agents and any resource selected by a decoded strobe.

---
 rtl/decoder_pkg.sv | 8 +
 rtl/onehot_decoder.sv | 16 +
 rtl/rr_decoder_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoded-select round-robin arbiter.
package decoder_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int DEFAULT_N = 32;

endpackage

// File: rtl/onehot_decoder.sv
// En-gated binary-to-one-hot decoder; the generalised form of the 5:32 decoder.
module onehot_decoder #(
    parameter int W = 5
) (
    input  logic [W-1:0]    Din,
    input  logic            En,
    output logic [2**W-1:0] Dout
);

    // NOTE: assigning a default before any conditional write keeps always_comb free of inferred latches.
    always_comb begin
        Dout = '0;
        if (En) Dout[Din] = 1'b1;
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter: holds a grant until Done, request drop or MAX_HOLD, and decodes it to Gnt.
module rr_decoder_arbiter
    import decoder_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int W        = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [N-1:0] Req,
    input  logic         Done,
    output logic [W-1:0] GntIdx,
    output logic         GntEn,
    output logic [N-1:0] Gnt,
    output logic         Timeout
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    arb_state_t    state, state_nxt;
    logic [W-1:0]  ptr, ptr_nxt;
    logic [W-1:0]  idx_nxt;
    logic          en_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;

    logic          found;
    logic [W-1:0]  pick;
    logic [W-1:0]  cand;
    logic          rel_done, rel_drop, rel_hold;

    // Rotating priority search; W-bit addition wraps mod N because N is a power of two.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int k = 0; k < N; k++) begin
            cand = ptr + W'(k);
            if (!found && Req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        rel_done  = Done;
        rel_drop  = !Req[GntIdx];
        rel_hold  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        state_nxt = state;
        idx_nxt   = GntIdx;
        en_nxt    = GntEn;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        Timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick;
                    en_nxt    = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
                if (rel_done || rel_drop || rel_hold) begin
                    state_nxt = IDLE;
                    en_nxt    = 1'b0;
                    ptr_nxt   = GntIdx + 1'b1;
                    // Timeout flags only a forced release; an explicit release or reset wins.
                    Timeout   = rel_hold && !rel_done && !rel_drop && !Rst;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            GntIdx   <= '0;
            GntEn    <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            GntIdx   <= idx_nxt;
            GntEn    <= en_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    onehot_decoder #(.W(W)) u_dec (
        .Din  (GntIdx),
        .En   (GntEn),
        .Dout (Gnt)
    );

endmodule
